// File: rtl/scene_renderer.sv
// scene_renderer: breakout game state machine plus a two-stage pixel classifier.
// Stage 1 registers the hit tests and stage 2 priority-encodes the result into a colour class.
module scene_renderer #(
  parameter int N_BLOCKS     = 16,
  parameter int BLK_W        = 40,
  parameter int BLK_H        = 20,
  parameter int PAD_W        = 80,
  parameter int PAD_H        = 10,
  parameter int BALL_R       = 2,
  parameter int FLASH_FRAMES = 30,
  localparam int IW = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  W,
  input  logic                  L,
  input  logic                  pix_valid,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [9:0]            ballx,
  input  logic [9:0]            bally,
  input  logic [9:0]            paddlex,
  input  logic [9:0]            paddley,
  input  logic [10*N_BLOCKS-1:0] blk_x,
  input  logic [10*N_BLOCKS-1:0] blk_y,
  input  logic [N_BLOCKS-1:0]   hit,
  output logic [2:0]            color,
  output logic                  color_valid,
  output logic [IW-1:0]         blk_idx
);
  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSS} state_t;
  state_t state_q, state_d;
  logic start_q, phase_q, phase_d, frame_start, fin, wrap;
  logic [7:0] frame_q, frame_d;
  logic [2:0] mode_col, mode_q, color_d;
  logic [10:0] x11, y11;
  logic pad_d, ball_d, pad_q, ball_q, play_q, v1_q;
  logic [N_BLOCKS-1:0] match_d, match_q;
  logic [IW-1:0] idx_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  // Counter and phase sit at zero outside WIN/LOSS, so entering an end screen starts clean.
  always_comb begin
    fin = state_q == WIN || state_q == LOSS;
    frame_start = pix_valid && x == '0 && y == '0;
    wrap = frame_start && frame_q == 8'(FLASH_FRAMES - 1);
    state_d = state_q == IDLE ? (start ? IDLE : PLAY)
            : state_q == PLAY ? (L ? LOSS : W ? WIN : PLAY)
            : (!start_q && start) ? IDLE : state_q;
    frame_d = (!fin || wrap) ? '0 : frame_q + 8'(frame_start);
    phase_d = fin && (phase_q ^ wrap);
  end
  always_comb
    mode_col = state_q == WIN  ? (phase_q ? 3'b011 : 3'b100)
             : state_q == LOSS ? (phase_q ? 3'b011 : 3'b101) : 3'b000;
  assign x11 = {1'b0, x};
  assign y11 = {1'b0, y};
  // 11-bit sums keep objects near the right/bottom edge from wrapping.
  always_comb begin
    pad_d = x11 > {1'b0, paddlex} && x11 < {1'b0, paddlex} + 11'(PAD_W) &&
            y11 > {1'b0, paddley} && y11 < {1'b0, paddley} + 11'(PAD_H);
    ball_d = x11 + 11'(BALL_R) > {1'b0, ballx} && x11 < {1'b0, ballx} + 11'(BALL_R) &&
             y11 + 11'(BALL_R) > {1'b0, bally} && y11 < {1'b0, bally} + 11'(BALL_R);
    for (int i = 0; i < N_BLOCKS; i++)
      match_d[i] = !hit[i] &&
                   x11 > {1'b0, blk_x[10*i +: 10]} && x11 < {1'b0, blk_x[10*i +: 10]} + 11'(BLK_W) &&
                   y11 > {1'b0, blk_y[10*i +: 10]} && y11 < {1'b0, blk_y[10*i +: 10]} + 11'(BLK_H);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1_q    <= 1'b0;
      pad_q   <= 1'b0;
      ball_q  <= 1'b0;
      play_q  <= 1'b0;
      mode_q  <= '0;
      match_q <= '0;
    end else begin
      v1_q    <= pix_valid;
      pad_q   <= pad_d;
      ball_q  <= ball_d;
      play_q  <= state_q == PLAY;
      mode_q  <= mode_col;
      match_q <= match_d;
    end
  always_comb begin
    idx_d = '0;
    for (int i = N_BLOCKS - 1; i >= 0; i--)
      if (match_q[i]) idx_d = IW'(i);
    color_d = !play_q ? mode_q : (pad_q || ball_q) ? 3'b001 : |match_q ? 3'b010 : 3'b011;
    idx_d = (color_d == 3'b010 && play_q) ? idx_d : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      color       <= 3'b111;
      color_valid <= 1'b0;
      blk_idx     <= '0;
    end else begin
      color_valid <= v1_q;
      if (v1_q) begin
        color   <= color_d;
        blk_idx <= idx_d;
      end
    end
endmodule

// File: tb/tb_scene_renderer.sv
// tb_scene_renderer: random and directed pixels scored against a behavioural game model.
module tb_scene_renderer;
  localparam int NB = 16, BW = 40, BH = 20, PW = 80, PH = 10, R = 2, FF = 30;
  localparam int S_IDLE = 0, S_PLAY = 1, S_WIN = 2, S_LOSS = 3;
  logic clk = 0, rst = 0, start = 1, W = 0, L = 0, pix_valid = 0;
  logic [9:0] x = 0, y = 0, ballx = 0, bally = 0, paddlex = 0, paddley = 0;
  logic [10*NB-1:0] blk_x, blk_y;
  logic [NB-1:0] hit = 0;
  logic [9:0] bxa[NB], bya[NB];
  logic [2:0] color;
  logic color_valid;
  logic [3:0] blk_idx;
  typedef struct {int c; int bi; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0;
  int mstate = S_IDLE, mframe = 0, mphase = 0;
  bit mstart_q = 1;
  logic [2:0] last_col = 3'b111;
  logic [3:0] last_idx = 0;

  scene_renderer #(.N_BLOCKS(NB), .BLK_W(BW), .BLK_H(BH), .PAD_W(PW), .PAD_H(PH),
                   .BALL_R(R), .FLASH_FRAMES(FF)) dut (
    .clk(clk), .rst(rst), .start(start), .W(W), .L(L), .pix_valid(pix_valid),
    .x(x), .y(y), .ballx(ballx), .bally(bally), .paddlex(paddlex), .paddley(paddley),
    .blk_x(blk_x), .blk_y(blk_y), .hit(hit),
    .color(color), .color_valid(color_valid), .blk_idx(blk_idx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb
    for (int i = 0; i < NB; i++) begin
      blk_x[10*i +: 10] = bxa[i];
      blk_y[10*i +: 10] = bya[i];
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit inside_open(input int p, input int lo, input int hi);
    return p > lo && p < hi;
  endfunction

  // Colour the spec's rules give for a pixel, under the current model state and scene.
  function automatic void classify(input int px, input int py, output int c, output int bi);
    bit obj;
    bi = 0;
    if (mstate == S_IDLE) c = 0;
    else if (mstate == S_WIN) c = mphase ? 3 : 4;
    else if (mstate == S_LOSS) c = mphase ? 3 : 5;
    else begin
      c = 3;
      for (int i = NB - 1; i >= 0; i--)
        if (!hit[i] && inside_open(px, int'(bxa[i]), int'(bxa[i]) + BW) &&
            inside_open(py, int'(bya[i]), int'(bya[i]) + BH)) begin
          c = 2;
          bi = i;
        end
      obj = (inside_open(px, int'(paddlex), int'(paddlex) + PW) &&
             inside_open(py, int'(paddley), int'(paddley) + PH)) ||
            (px + R > int'(ballx) && px < int'(ballx) + R &&
             py + R > int'(bally) && py < int'(bally) + R);
      if (obj) begin
        c = 1;
        bi = 0;
      end
    end
  endfunction

  task automatic model_reset();
    mstate = S_IDLE; mframe = 0; mphase = 0; mstart_q = 1;
  endtask

  task automatic model_step();
    bit fs;
    fs = pix_valid && x == 0 && y == 0;
    if (mstate == S_WIN || mstate == S_LOSS) begin
      if (fs) begin
        mframe++;
        if (mframe == FF) begin
          mframe = 0;
          mphase ^= 1;
        end
      end
    end else begin
      mframe = 0;
      mphase = 0;
    end
    case (mstate)
      S_IDLE: if (!start) mstate = S_PLAY;
      S_PLAY: if (L) mstate = S_LOSS; else if (W) mstate = S_WIN;
      default: if (!mstart_q && start) mstate = S_IDLE;
    endcase
    mstart_q = start;
  endtask

  // One clock of stimulus; ec>=0 pins the expected colour to a hand-derived value.
  task automatic drive(input bit pv, input int px = 0, input int py = 0, input int ec = -1, input int ei = 0);
    int c, bi;
    pix_valid = pv;
    x = px[9:0];
    y = py[9:0];
    if (pv) begin
      classify(px, py, c, bi);
      if (ec >= 0) begin
        c = ec;
        bi = ei;
      end
      q.push_back('{c, bi, cyc});
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic place_default();
    for (int i = 0; i < NB; i++) begin
      bxa[i] = 10'(i * 60);
      bya[i] = 10'd600;
    end
    hit = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      last_col = 3'b111;
      last_idx = '0;
    end
    if (color_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid color=%0d cyc=%0d expected no output", color, cyc);
      end else begin
        e = q.pop_front();
        chk("color", int'(color), e.c);
        chk("blk_idx", int'(blk_idx), e.bi);
        chk("latency", cyc, e.cyc + 2);
      end
      last_col = color;
      last_idx = blk_idx;
    end else begin
      checks++;
      if (color !== last_col || blk_idx !== last_idx) begin
        failures++;
        $display("FAIL hold color=%0d idx=%0d expected color=%0d idx=%0d", color, blk_idx, last_col, last_idx);
      end
    end
  end

  initial begin
    int pick, tx, ty, px, py;
    place_default();
    ballx = 900; bally = 900; paddlex = 100; paddley = 400;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_color", int'(color), 7);
    chk("reset_valid", int'(color_valid), 0);
    chk("reset_idx", int'(blk_idx), 0);
    rst = 1;
    for (int i = 0; i < 6; i++) drive(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0);
    start = 0; drive(0); start = 1;
    drive(1, 150, 405, 1); drive(1, 100, 405, 3); drive(1, 179, 405, 1);
    drive(1, 180, 405, 3); drive(1, 150, 400, 3); drive(1, 150, 409, 1);
    bxa[3] = 50; bya[3] = 20; bxa[5] = 40; bya[5] = 25;
    drive(1, 60, 30, 2, 3);
    hit[3] = 1; drive(1, 60, 30, 2, 5); hit[3] = 0;
    ballx = 1; bally = 1;
    drive(1, 0, 0, 1); drive(1, 2, 2, 1); drive(1, 3, 3, 3);
    ballx = 60; bally = 30; drive(1, 60, 30, 1);
    ballx = 900; bally = 900;
    bxa[0] = 1000; bya[0] = 1010;
    drive(1, 1020, 1020, 2, 0); drive(1, 1023, 1023, 2, 0); drive(1, 1000, 1020, 3);
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        for (int i = 0; i < NB; i++) begin
          bxa[i] = (i == NB - 1) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 300));
          bya[i] = (i == NB - 1) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 200));
        end
        hit = NB'($urandom);
      end
      if (n % 10 == 0) begin
        ballx = 10'($urandom_range(0, 1023)); bally = 10'($urandom_range(0, 1023));
        paddlex = 10'($urandom_range(0, 400)); paddley = 10'($urandom_range(0, 300));
      end
      pick = int'($urandom_range(0, NB + 1));
      tx = pick == NB ? int'(paddlex) : pick == NB + 1 ? int'(ballx) : int'(bxa[pick]);
      ty = pick == NB ? int'(paddley) : pick == NB + 1 ? int'(bally) : int'(bya[pick]);
      px = tx + int'($urandom_range(0, 88)) - 4;
      py = ty + int'($urandom_range(0, 28)) - 4;
      px = px > 1023 ? 1023 : px < 0 ? 0 : px;
      py = py > 1023 ? 1023 : py < 0 ? 0 : py;
      drive($urandom_range(0, 4) != 0, px, py);
    end
    W = 1; L = 1; drive(0); W = 0; L = 0;
    drive(1, 5, 5, 5);
    for (int i = 0; i < FF; i++) drive(1, 0, 0);
    drive(1, 5, 5, 3);
    for (int i = 0; i < FF; i++) drive(1, 0, 0);
    drive(1, 5, 5, 5);
    start = 0; drive(0); start = 1; drive(0);
    drive(1, 5, 5, 0);
    start = 0; drive(0); start = 1; drive(0);
    W = 1; drive(0); W = 0;
    drive(1, 7, 7, 4);
    L = 1; drive(1, 7, 7, 4); L = 0;
    start = 0; drive(0); drive(0); start = 1; drive(0);
    drive(1, 7, 7, 0);
    start = 0; drive(0); start = 1;
    for (int i = 0; i < 4; i++) drive(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    rst = 0;
    q.delete();
    model_reset();
    #1;
    chk("midreset_color", int'(color), 7);
    chk("midreset_valid", int'(color_valid), 0);
    chk("midreset_idx", int'(blk_idx), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < 4; i++) drive(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0);
    drive(0); drive(0); drive(0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
